// File: rtl/ysyx_23060096_regfile_mp.sv
// ysyx_23060096_regfile_mp: multi-port general-purpose register file for the NPC core.
//
// - Configurable read (NR_RD) and write (NR_WR) port counts.
// - x0 is hardwired to zero.
// - Reads are registered, with a per-port enable.
// - A per-register busy scoreboard is set at issue and cleared at writeback.
// - A sticky flag reports two write ports hitting the same register in one cycle.
//
// Optional build macro YSYX_RF_BYPASS_EN adds write-to-read forwarding in the
// read-data/rbusy muxes. All other logic is identical with or without it.
module ysyx_23060096_regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2,
    parameter int NR_WR      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NR_RD-1:0]                 rd_en,
    input  logic [NR_RD*ADDR_WIDTH-1:0]      raddr,
    output logic [NR_RD*DATA_WIDTH-1:0]      rdata,
    output logic [NR_RD-1:0]                 rbusy,
    input  logic [NR_WR-1:0]                 wen,
    input  logic [NR_WR*ADDR_WIDTH-1:0]      waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0]      wdata,
    input  logic                             iss_valid,
    input  logic [ADDR_WIDTH-1:0]            iss_rd,
    output logic [(1<<ADDR_WIDTH)-1:0]       busy,
    output logic                             wr_conflict
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [NREG];

    logic [ADDR_WIDTH-1:0] ra [NR_RD];
    logic [ADDR_WIDTH-1:0] wa [NR_WR];
    logic [DATA_WIDTH-1:0] wd [NR_WR];
    logic [NR_WR-1:0]      wr_act;
    logic                  conflict_now;
    logic [NREG-1:0]       busy_next;
    logic [DATA_WIDTH-1:0] rd_val [NR_RD];
    logic [NR_RD-1:0]      rb_val;

    // Unpack the flat port buses; a write is active only if it is enabled and not aimed at x0.
    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NR_RD; i++) begin
            ra[i] = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int j = 0; j < NR_WR; j++) begin
            wa[j]     = waddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            wd[j]     = wdata[j*DATA_WIDTH +: DATA_WIDTH];
            wr_act[j] = wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0);
        end
    end

    // Detect two active write ports targeting the same register in this cycle.
    always_comb begin
        conflict_now = 1'b0;
        for (int j = 0; j < NR_WR; j++) begin
            for (int k = j + 1; k < NR_WR; k++) begin
                if (wr_act[j] && wr_act[k] && (wa[j] == wa[k])) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    // Register array. A later port's assignment overrides an earlier one, so the highest index wins.
    // NOTE: the array is reset because the core expects every GPR to read as zero after reset.
    // NOTE: state is updated with non-blocking assignments so that all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NR_WR; j++) begin
                if (wr_act[j]) begin
                    rf[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears a bit, issue sets it, and issue wins on a collision.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NR_WR; j++) begin
            if (wr_act[j]) begin
                busy_next[wa[j]] = 1'b0;
            end
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard flops and the sticky conflict flag. The flag is cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            wr_conflict <= 1'b0;
        end else begin
            busy <= busy_next;
            if (conflict_now) begin
                wr_conflict <= 1'b1;
            end
        end
    end

    // Read-side muxes. These return pre-edge contents, or same-cycle write data when forwarding is built in.
    always_comb begin
        for (int i = 0; i < NR_RD; i++) begin
            rd_val[i] = rf[ra[i]];
            rb_val[i] = busy[ra[i]];
`ifdef YSYX_RF_BYPASS_EN
            for (int j = 0; j < NR_WR; j++) begin
                if (wr_act[j] && (wa[j] == ra[i])) begin
                    rd_val[i] = wd[j];
                    rb_val[i] = iss_valid && (iss_rd == ra[i]);
                end
            end
`endif
            if (ra[i] == '0) begin
                rd_val[i] = '0;
                rb_val[i] = 1'b0;
            end
        end
    end

    // Registered read ports. A port holds its last result while its enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            rbusy <= '0;
        end else begin
            for (int i = 0; i < NR_RD; i++) begin
                if (rd_en[i]) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] <= rd_val[i];
                    rbusy[i]                          <= rb_val[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_regfile_mp.sv
// Directed self-checking bench for ysyx_23060096_regfile_mp using the default parameters.
module tb_ysyx_23060096_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        wr_conflict;

    int tests = 0;
    int fails = 0;

    ysyx_23060096_regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .busy        (busy),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en = 2'b00; wen = 2'b00; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        rst = 1'b1; raddr = '0; idle();
        tick(); tick();
        chk("reset_rdata", rdata, 64'h0);
        chk("reset_busy", {32'h0, busy}, 64'h0);
        chk("reset_conflict", {63'h0, wr_conflict}, 64'h0);
        chk("reset_rbusy", {62'h0, rbusy}, 64'h0);
        rst = 1'b0;

        // Read after reset
        rd_en = 2'b11; raddr = {5'd3, 5'd0};
        tick();
        chk("post_reset_read", rdata, 64'h0);

        // Basic write then read, checking one-cycle latency
        idle(); wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        tick();
        idle(); rd_en = 2'b01; raddr = {5'd0, 5'd5};
        #2;
        chk("latency_before_edge", {32'h0, rdata[31:0]}, 64'h0);
        tick();
        chk("basic_read", {32'h0, rdata[31:0]}, 64'h0000_0000_DEAD_BEEF);

        // x0 protection
        idle(); wen = 2'b11; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'hFFFFFFFF};
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        idle(); rd_en = 2'b11; raddr = {5'd0, 5'd0};
        tick();
        chk("x0_rdata", rdata, 64'h0);
        chk("x0_busy", {32'h0, busy}, 64'h0);
        chk("x0_conflict", {63'h0, wr_conflict}, 64'h0);

        // Scoreboard: issue, read busy, write+reissue, final write clears
        idle(); iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        chk("sb_issue", {32'h0, busy}, 64'h0000_0000_0000_0200);
        idle(); rd_en = 2'b10; raddr = {5'd9, 5'd0};
        tick();
        chk("sb_rbusy", {62'h0, rbusy}, 64'h2);
        idle(); wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h99, 32'h0};
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        chk("sb_set_wins", {32'h0, busy}, 64'h0000_0000_0000_0200);
        idle(); wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h77, 32'h0};
        tick();
        chk("sb_clear", {32'h0, busy}, 64'h0);
        idle(); rd_en = 2'b11; raddr = {5'd9, 5'd9};
        tick();
        chk("sb_data_both_ports", rdata, {32'h77, 32'h77});
        chk("sb_rbusy_cleared", {62'h0, rbusy}, 64'h0);

        // Same-cycle read/write of register 4 with no pending issue
        idle(); wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hA};
        tick();
        chk("write_not_busy_sb", {32'h0, busy}, 64'h0);
        idle(); rd_en = 2'b01; raddr = {5'd0, 5'd4};
        wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hB};
        tick();
`ifdef YSYX_RF_BYPASS_EN
        chk("rw_same_cycle", {32'h0, rdata[31:0]}, 64'hB);
`else
        chk("rw_same_cycle", {32'h0, rdata[31:0]}, 64'hA);
`endif
        chk("rw_same_rbusy", {63'h0, rbusy[0]}, 64'h0);
        idle(); rd_en = 2'b01; raddr = {5'd0, 5'd4};
        tick();
        chk("rw_after", {32'h0, rdata[31:0]}, 64'hB);

        // Write conflict: highest port wins, flag is sticky
        idle(); wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2, 32'h1};
        tick();
        chk("conflict_set", {63'h0, wr_conflict}, 64'h1);
        idle(); rd_en = 2'b11; raddr = {5'd7, 5'd7};
        tick();
        chk("conflict_winner", rdata, {32'h2, 32'h2});
        idle(); raddr = {5'd4, 5'd4};
        tick(); tick();
        chk("conflict_sticky", {63'h0, wr_conflict}, 64'h1);
        chk("rd_en_low_hold", rdata, {32'h2, 32'h2});

        // Asynchronous reset mid-operation discards that cycle's write and issue
        idle(); wen = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h1234};
        iss_valid = 1'b1; iss_rd = 5'd10;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_rdata", rdata, 64'h0);
        chk("async_reset_conflict", {63'h0, wr_conflict}, 64'h0);
        tick();
        chk("async_reset_busy", {32'h0, busy}, 64'h0);
        rst = 1'b0; idle(); rd_en = 2'b11; raddr = {5'd10, 5'd7};
        tick();
        chk("reset_cleared_regs", rdata, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
